// File: rtl/mips_ctrl_pkg.sv
// Shared constants for the multi-cycle MIPS control unit: opcodes, ALU
// operation codes, state encodings, datapath select values and the
// control word that the output decoder hands back to the FSM.
package mips_ctrl_pkg;

  localparam logic [5:0] OP_RTYPE = 6'b000000;
  localparam logic [5:0] OP_ADDI  = 6'b001000;
  localparam logic [5:0] OP_ANDI  = 6'b001100;
  localparam logic [5:0] OP_ORI   = 6'b001101;
  localparam logic [5:0] OP_SLTI  = 6'b001010;
  localparam logic [5:0] OP_LW    = 6'b100011;
  localparam logic [5:0] OP_SW    = 6'b101011;
  localparam logic [5:0] OP_BEQ   = 6'b000100;
  localparam logic [5:0] OP_J     = 6'b000010;

  localparam logic [2:0] ALU_RFUNCT = 3'b001;
  localparam logic [2:0] ALU_ADD    = 3'b110;
  localparam logic [2:0] ALU_AND    = 3'b011;
  localparam logic [2:0] ALU_OR     = 3'b100;
  localparam logic [2:0] ALU_SLT    = 3'b010;
  localparam logic [2:0] ALU_SUB    = 3'b101;

  localparam logic [3:0] S_FETCH     = 4'd0;
  localparam logic [3:0] S_DECODE    = 4'd1;
  localparam logic [3:0] S_MEM_ADDR  = 4'd2;
  localparam logic [3:0] S_MEM_READ  = 4'd3;
  localparam logic [3:0] S_MEM_WB    = 4'd4;
  localparam logic [3:0] S_MEM_WRITE = 4'd5;
  localparam logic [3:0] S_R_EXEC    = 4'd6;
  localparam logic [3:0] S_R_WB      = 4'd7;
  localparam logic [3:0] S_BRANCH    = 4'd8;
  localparam logic [3:0] S_JUMP      = 4'd9;
  localparam logic [3:0] S_I_EXEC    = 4'd10;
  localparam logic [3:0] S_I_WB      = 4'd11;
  localparam logic [3:0] S_TRAP      = 4'd12;

  localparam logic [1:0] SRCB_B       = 2'b00;
  localparam logic [1:0] SRCB_FOUR    = 2'b01;
  localparam logic [1:0] SRCB_IMM     = 2'b10;
  localparam logic [1:0] SRCB_IMM_SH2 = 2'b11;

  localparam logic [1:0] PCSRC_ALU    = 2'b00;
  localparam logic [1:0] PCSRC_ALUOUT = 2'b01;
  localparam logic [1:0] PCSRC_JUMP   = 2'b10;

  typedef struct packed {
    logic       pcWrite;
    logic       pcWriteCond;
    logic       iorD;
    logic       memRead;
    logic       memWrite;
    logic       irWrite;
    logic       memToReg;
    logic       regDst;
    logic       regWrite;
    logic       aluSrcA;
    logic [1:0] aluSrcB;
    logic [2:0] aluOp;
    logic [1:0] pcSource;
    logic       finInstr;
  } ctrlWord_t;

  // States that wait on the memory handshake and run the timeout counter.
  function automatic logic isMemState(input logic [3:0] s);
    return (s == S_FETCH) || (s == S_MEM_READ) || (s == S_MEM_WRITE);
  endfunction

endpackage

// File: rtl/deco_salidas_estado.sv
// Combinational control-word decoder: maps the current state, the latched
// opcode and the memory handshake to every datapath select and strobe.
// Ports:
//   estado   - current FSM state
//   opQ      - opcode captured in DECODE
//   memReady - memory completes the current access this cycle
//   ctrl     - full control word (strobes not yet reset-gated)
module deco_salidas_estado
  import mips_ctrl_pkg::*;
(
  input  logic [3:0] estado,
  input  logic [5:0] opQ,
  input  logic       memReady,
  output ctrlWord_t  ctrl
);

  always_comb begin
    ctrl = '0;
    case (estado)
      S_FETCH: begin
        ctrl.memRead  = 1'b1;
        ctrl.aluSrcB  = SRCB_FOUR;
        ctrl.aluOp    = ALU_ADD;
        ctrl.irWrite  = memReady;
        ctrl.pcWrite  = memReady;
      end
      S_DECODE: begin
        // Branch target is computed speculatively into ALUOut here.
        ctrl.aluSrcB = SRCB_IMM_SH2;
        ctrl.aluOp   = ALU_ADD;
      end
      S_MEM_ADDR: begin
        ctrl.aluSrcA = 1'b1;
        ctrl.aluSrcB = SRCB_IMM;
        ctrl.aluOp   = ALU_ADD;
      end
      S_MEM_READ: begin
        ctrl.memRead = 1'b1;
        ctrl.iorD    = 1'b1;
      end
      S_MEM_WB: begin
        ctrl.memToReg = 1'b1;
        ctrl.regWrite = 1'b1;
        ctrl.finInstr = 1'b1;
      end
      S_MEM_WRITE: begin
        ctrl.memWrite = 1'b1;
        ctrl.iorD     = 1'b1;
        ctrl.finInstr = memReady;
      end
      S_R_EXEC: begin
        ctrl.aluSrcA = 1'b1;
        ctrl.aluSrcB = SRCB_B;
        ctrl.aluOp   = ALU_RFUNCT;
      end
      S_R_WB: begin
        ctrl.regDst   = 1'b1;
        ctrl.regWrite = 1'b1;
        ctrl.finInstr = 1'b1;
      end
      S_BRANCH: begin
        ctrl.aluSrcA     = 1'b1;
        ctrl.aluSrcB     = SRCB_B;
        ctrl.aluOp       = ALU_SUB;
        ctrl.pcWriteCond = 1'b1;
        ctrl.pcSource    = PCSRC_ALUOUT;
        ctrl.finInstr    = 1'b1;
      end
      S_JUMP: begin
        ctrl.pcWrite  = 1'b1;
        ctrl.pcSource = PCSRC_JUMP;
        ctrl.finInstr = 1'b1;
      end
      S_I_EXEC: begin
        ctrl.aluSrcA = 1'b1;
        ctrl.aluSrcB = SRCB_IMM;
        case (opQ)
          OP_ANDI: ctrl.aluOp = ALU_AND;
          OP_ORI:  ctrl.aluOp = ALU_OR;
          OP_SLTI: ctrl.aluOp = ALU_SLT;
          default: ctrl.aluOp = ALU_ADD;
        endcase
      end
      S_I_WB: begin
        ctrl.regWrite = 1'b1;
        ctrl.finInstr = 1'b1;
      end
      default: ;
    endcase
  end

endmodule

// File: rtl/unidad_control_multiciclo.sv
// Multi-cycle MIPS control unit: sequences the shared memory/ALU datapath,
// stalls on the memory handshake, traps on unsupported opcodes or memory
// timeouts, and counts retired instructions.
// Ports:
//   clk, rst            - clock, synchronous active-high reset
//   op, mem_ready       - IR opcode field, memory access done
//   PCWrite..PCSource   - datapath selects and write strobes
//   estado              - current state (debug)
//   fin_instr           - last cycle of each instruction
//   excepcion           - sticky trap flag
//   instr_count         - retired instruction count (wraps)
//
// state       | meaning
// ------------+------------------------------------------------
// FETCH   0   | read instruction at PC, PC+4 -> PC on ready
// DECODE  1   | latch opcode, branch target -> ALUOut
// MEM_ADDR 2  | A + imm -> ALUOut
// MEM_READ 3  | read data memory at ALUOut
// MEM_WB  4   | MDR -> rt
// MEM_WRITE 5 | write B to memory at ALUOut
// R_EXEC  6   | A funct B
// R_WB    7   | ALUOut -> rd
// BRANCH  8   | A - B, load PC from ALUOut if zero
// JUMP    9   | load jump target
// I_EXEC  10  | A op imm
// I_WB    11  | ALUOut -> rt
// TRAP    12  | halted, only rst leaves
module unidad_control_multiciclo
  import mips_ctrl_pkg::*;
#(
  parameter int CNT_W    = 32,
  parameter int WAIT_MAX = 255
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [5:0]       op,
  input  logic             mem_ready,
  output logic             PCWrite,
  output logic             PCWriteCond,
  output logic             IorD,
  output logic             MemRead,
  output logic             MemWrite,
  output logic             IRWrite,
  output logic             MemToReg,
  output logic             RegDst,
  output logic             RegWrite,
  output logic             AluSrcA,
  output logic [1:0]       AluSrcB,
  output logic [2:0]       AluOp,
  output logic [1:0]       PCSource,
  output logic [3:0]       estado,
  output logic             fin_instr,
  output logic             excepcion,
  output logic [CNT_W-1:0] instr_count
);

  localparam int WAIT_W = (WAIT_MAX < 2) ? 1 : $clog2(WAIT_MAX + 1);

  logic [3:0]        state;
  logic [3:0]        stateNext;
  logic [5:0]        opQ;
  logic [WAIT_W-1:0] waitCnt;
  logic              timeout;
  ctrlWord_t         ctrl;

  deco_salidas_estado uDeco (
    .estado   (state),
    .opQ      (opQ),
    .memReady (mem_ready),
    .ctrl     (ctrl)
  );

  // Trap when this stall cycle would take the count up to WAIT_MAX; a ready
  // on that same cycle still completes the access.
  assign timeout = (WAIT_MAX != 0) && !mem_ready && isMemState(state) &&
                   (waitCnt == WAIT_W'(WAIT_MAX - 1));

  always_comb begin
    stateNext = state;
    case (state)
      S_FETCH: begin
        if (mem_ready)    stateNext = S_DECODE;
        else if (timeout) stateNext = S_TRAP;
      end
      S_DECODE: begin
        case (op)
          OP_LW, OP_SW:                     stateNext = S_MEM_ADDR;
          OP_RTYPE:                         stateNext = S_R_EXEC;
          OP_BEQ:                           stateNext = S_BRANCH;
          OP_J:                             stateNext = S_JUMP;
          OP_ADDI, OP_ANDI, OP_ORI, OP_SLTI: stateNext = S_I_EXEC;
          default:                          stateNext = S_TRAP;
        endcase
      end
      S_MEM_ADDR: stateNext = (opQ == OP_LW) ? S_MEM_READ : S_MEM_WRITE;
      S_MEM_READ: begin
        if (mem_ready)    stateNext = S_MEM_WB;
        else if (timeout) stateNext = S_TRAP;
      end
      S_MEM_WRITE: begin
        if (mem_ready)    stateNext = S_FETCH;
        else if (timeout) stateNext = S_TRAP;
      end
      S_MEM_WB, S_R_WB, S_BRANCH, S_JUMP, S_I_WB: stateNext = S_FETCH;
      S_R_EXEC:  stateNext = S_R_WB;
      S_I_EXEC:  stateNext = S_I_WB;
      S_TRAP:    stateNext = S_TRAP;
      default:   stateNext = S_TRAP;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state       <= S_FETCH;
      opQ         <= '0;
      waitCnt     <= '0;
      instr_count <= '0;
      excepcion   <= 1'b0;
    end else begin
      state <= stateNext;
      if (state == S_DECODE) opQ <= op;
      // Any state change restarts the count, so every memory state is
      // entered with a clean counter.
      if (stateNext != state)
        waitCnt <= '0;
      else if (isMemState(state) && !mem_ready)
        waitCnt <= waitCnt + WAIT_W'(1);
      if (ctrl.finInstr) instr_count <= instr_count + CNT_W'(1);
      if (stateNext == S_TRAP) excepcion <= 1'b1;
    end
  end

  assign PCWrite     = ctrl.pcWrite     & ~rst;
  assign PCWriteCond = ctrl.pcWriteCond & ~rst;
  assign MemRead     = ctrl.memRead     & ~rst;
  assign MemWrite    = ctrl.memWrite    & ~rst;
  assign IRWrite     = ctrl.irWrite     & ~rst;
  assign RegWrite    = ctrl.regWrite    & ~rst;
  assign fin_instr   = ctrl.finInstr    & ~rst;
  assign IorD        = ctrl.iorD;
  assign MemToReg    = ctrl.memToReg;
  assign RegDst      = ctrl.regDst;
  assign AluSrcA     = ctrl.aluSrcA;
  assign AluSrcB     = ctrl.aluSrcB;
  assign AluOp       = ctrl.aluOp;
  assign PCSource    = ctrl.pcSource;
  assign estado      = state;

endmodule

// File: tb/tb_unidad_control_multiciclo.sv
module tb_unidad_control_multiciclo;

  logic       clk;
  logic       rst;
  logic [5:0] op;
  logic       mem_ready;
  logic       PCWrite, PCWriteCond, IorD, MemRead, MemWrite, IRWrite;
  logic       MemToReg, RegDst, RegWrite, AluSrcA;
  logic [1:0] AluSrcB, PCSource;
  logic [2:0] AluOp;
  logic [3:0] estado;
  logic       fin_instr, excepcion;
  logic [3:0] instr_count;

  unidad_control_multiciclo #(.CNT_W(4), .WAIT_MAX(4)) dut (
    .clk(clk), .rst(rst), .op(op), .mem_ready(mem_ready),
    .PCWrite(PCWrite), .PCWriteCond(PCWriteCond), .IorD(IorD),
    .MemRead(MemRead), .MemWrite(MemWrite), .IRWrite(IRWrite),
    .MemToReg(MemToReg), .RegDst(RegDst), .RegWrite(RegWrite),
    .AluSrcA(AluSrcA), .AluSrcB(AluSrcB), .AluOp(AluOp),
    .PCSource(PCSource), .estado(estado), .fin_instr(fin_instr),
    .excepcion(excepcion), .instr_count(instr_count)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // -1 in a field means "not checked this cycle".
  typedef struct {
    int st, pcw, pcwc, iord, mrd, mwr, irw, m2r, rdst, rw;
    int srcA, srcB, aluop, pcsrc, fin, exc, cnt;
  } exp_t;

  exp_t sb[$];
  exp_t monE;
  int   checks = 0;
  int   errors = 0;
  int   expCnt = 0;

  task automatic chk(input string nm, input int act, input int ex);
    if (ex < 0) return;
    checks++;
    if (act != ex) begin
      errors++;
      $display("FAIL %s at %0t: got %0d expected %0d", nm, $time, act, ex);
    end
  endtask

  always @(negedge clk) begin
    if (sb.size() > 0) begin
      monE = sb.pop_front();
      chk("estado",      int'(estado),      monE.st);
      chk("PCWrite",     int'(PCWrite),     monE.pcw);
      chk("PCWriteCond", int'(PCWriteCond), monE.pcwc);
      chk("IorD",        int'(IorD),        monE.iord);
      chk("MemRead",     int'(MemRead),     monE.mrd);
      chk("MemWrite",    int'(MemWrite),    monE.mwr);
      chk("IRWrite",     int'(IRWrite),     monE.irw);
      chk("MemToReg",    int'(MemToReg),    monE.m2r);
      chk("RegDst",      int'(RegDst),      monE.rdst);
      chk("RegWrite",    int'(RegWrite),    monE.rw);
      chk("AluSrcA",     int'(AluSrcA),     monE.srcA);
      chk("AluSrcB",     int'(AluSrcB),     monE.srcB);
      chk("AluOp",       int'(AluOp),       monE.aluop);
      chk("PCSource",    int'(PCSource),    monE.pcsrc);
      chk("fin_instr",   int'(fin_instr),   monE.fin);
      chk("excepcion",   int'(excepcion),   monE.exc);
      chk("instr_count", int'(instr_count), monE.cnt);
    end
  end

  // Strobes and the trap flag default to 0; mux selects default to unchecked.
  function automatic exp_t base(input int st);
    exp_t e;
    e.st = st; e.pcw = 0; e.pcwc = 0; e.mrd = 0; e.mwr = 0; e.irw = 0;
    e.rw = 0; e.fin = 0; e.exc = 0;
    e.iord = -1; e.m2r = -1; e.rdst = -1; e.srcA = -1; e.srcB = -1;
    e.aluop = -1; e.pcsrc = -1; e.cnt = -1;
    return e;
  endfunction

  task automatic cyc(input logic r, input logic rdy, input logic [5:0] o,
                     input exp_t e);
    @(posedge clk);
    #1;
    rst = r; mem_ready = rdy; op = o;
    sb.push_back(e);
  endtask

  task automatic fetchOk(input logic [5:0] o);
    exp_t e = base(0);
    e.mrd = 1; e.irw = 1; e.pcw = 1; e.iord = 0; e.srcA = 0; e.srcB = 1;
    e.aluop = 6; e.pcsrc = 0; e.cnt = expCnt % 16;
    cyc(0, 1, o, e);
  endtask

  task automatic decodeOk(input logic [5:0] o);
    exp_t e = base(1);
    e.srcA = 0; e.srcB = 3; e.aluop = 6;
    cyc(0, 1, o, e);
  endtask

  task automatic jumpInstr();
    exp_t e;
    fetchOk(6'b000010);
    decodeOk(6'b000010);
    e = base(9); e.pcw = 1; e.pcsrc = 2; e.fin = 1;
    cyc(0, 1, 6'b000010, e);
    expCnt++;
  endtask

  initial begin
    exp_t e;
    logic [5:0] iOps[4];
    int         iAlu[4];
    iOps = '{6'b001000, 6'b001100, 6'b001101, 6'b001010};
    iAlu = '{6, 3, 4, 2};
    rst = 1'b1; mem_ready = 1'b0; op = 6'd0;

    // Reset: strobes forced low even with mem_ready high in FETCH.
    e = base(-1); e.exc = -1;
    cyc(1, 0, 6'd0, e);
    e = base(0); e.cnt = 0;
    cyc(1, 1, 6'b100011, e);

    // lw, zero wait: 0,1,2,3,4
    fetchOk(6'b100011);
    decodeOk(6'b100011);
    e = base(2); e.srcA = 1; e.srcB = 2; e.aluop = 6;
    cyc(0, 1, 6'b100011, e);
    e = base(3); e.mrd = 1; e.iord = 1;
    cyc(0, 1, 6'b100011, e);
    e = base(4); e.rdst = 0; e.m2r = 1; e.rw = 1; e.fin = 1;
    cyc(0, 1, 6'b100011, e);
    expCnt++;

    // R-type
    fetchOk(6'b000000);
    decodeOk(6'b000000);
    e = base(6); e.srcA = 1; e.srcB = 0; e.aluop = 1;
    cyc(0, 1, 6'b000000, e);
    e = base(7); e.rdst = 1; e.m2r = 0; e.rw = 1; e.fin = 1;
    cyc(0, 1, 6'b000000, e);
    expCnt++;

    // addi, andi, ori, slti
    for (int i = 0; i < 4; i++) begin
      fetchOk(iOps[i]);
      decodeOk(iOps[i]);
      e = base(10); e.srcA = 1; e.srcB = 2; e.aluop = iAlu[i];
      cyc(0, 1, iOps[i], e);
      e = base(11); e.rdst = 0; e.m2r = 0; e.rw = 1; e.fin = 1;
      cyc(0, 1, iOps[i], e);
      expCnt++;
    end

    // sw with 3 stall cycles in MEM_WRITE (one short of the timeout)
    fetchOk(6'b101011);
    decodeOk(6'b101011);
    e = base(2); e.srcA = 1; e.srcB = 2; e.aluop = 6;
    cyc(0, 1, 6'b101011, e);
    for (int i = 0; i < 3; i++) begin
      e = base(5); e.mwr = 1; e.iord = 1;
      cyc(0, 0, 6'b101011, e);
    end
    e = base(5); e.mwr = 1; e.iord = 1; e.fin = 1;
    cyc(0, 1, 6'b101011, e);
    expCnt++;

    // beq then j
    fetchOk(6'b000100);
    decodeOk(6'b000100);
    e = base(8); e.srcA = 1; e.srcB = 0; e.aluop = 5; e.pcwc = 1;
    e.pcsrc = 1; e.fin = 1;
    cyc(0, 1, 6'b000100, e);
    expCnt++;
    jumpInstr();

    // Run the 4-bit counter through its wrap (16 -> 0 -> 1)
    while (expCnt < 17) jumpInstr();

    // Unsupported opcode traps; flag sticky, strobes quiet
    fetchOk(6'b111111);
    decodeOk(6'b111111);
    for (int i = 0; i < 10; i++) begin
      e = base(12); e.exc = 1;
      cyc(0, i[0], 6'b111111, e);
    end
    e = base(12); e.exc = 1;
    cyc(1, 1, 6'b111111, e);
    expCnt = 0;

    // FETCH timeout: 4 stalled cycles then TRAP
    for (int i = 0; i < 4; i++) begin
      e = base(0); e.mrd = 1; e.cnt = 0;
      cyc(0, 0, 6'b100011, e);
    end
    e = base(12); e.exc = 1;
    cyc(0, 0, 6'b100011, e);
    e = base(12); e.exc = 1;
    cyc(1, 0, 6'b100011, e);

    // Ready on the 4th cycle wins over the timeout
    for (int i = 0; i < 3; i++) begin
      e = base(0); e.mrd = 1;
      cyc(0, 0, 6'b100011, e);
    end
    fetchOk(6'b100011);
    decodeOk(6'b100011);
    e = base(2); e.srcA = 1; e.srcB = 2; e.aluop = 6;
    cyc(0, 1, 6'b100011, e);

    // Reset in MEM_READ aborts the load; RegWrite never rises
    e = base(3); e.mrd = 1; e.iord = 1;
    cyc(0, 0, 6'b100011, e);
    e = base(3);
    cyc(1, 0, 6'b100011, e);
    fetchOk(6'b100011);
    decodeOk(6'b100011);

    @(negedge clk);
    #1;
    if (sb.size() != 0) begin
      errors++;
      $display("FAIL scoreboard_drain: got %0d pending expected 0", sb.size());
    end
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #100000;
    errors++;
    $display("FAIL watchdog: got timeout expected completion");
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
